// File: rtl/rf_pkg.sv
// Shared definitions for the register-file context save/restore sequencer.
package rf_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 8;
  localparam int SELW_DEF  = $clog2(NREGS_DEF);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SAVE_RD  = 3'd1,
    ST_SAVE_OUT = 3'd2,
    ST_RESTORE  = 3'd3,
    ST_DONE     = 3'd4
  } ctx_state_t;

endpackage

// File: rtl/ctx_idx_counter.sv
// Register index counter for the context sequencer: clear, saturating
// increment and a flag marking the last register.
module ctx_idx_counter
  import rf_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [SELW-1:0] idx,
  output logic            last
);

  // Index register; clear wins, and the index never steps past the last register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (inc && !last) begin
      idx <= idx + 1'b1;
    end
  end

  assign last = (idx == SELW'(NREGS - 1));

endmodule

// File: rtl/rf_ctx_seq.sv
// Context sequencer: streams the register file out (save) or loads it from
// an input stream (restore), one register per handshake.
//
// state       | meaning
// ------------+------------------------------------------------------
// ST_IDLE     | waiting for start; mode picks save or restore
// ST_SAVE_RD  | read register idx, capture it into out_data
// ST_SAVE_OUT | out_valid held until out_ready; then next reg or done
// ST_RESTORE  | in_ready=1, each in_valid writes register idx
// ST_DONE     | one-cycle done pulse, back to idle
module rf_ctx_seq
  import rf_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int SELW  = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [SELW-1:0]  rf_read1regsel,
  input  logic [WIDTH-1:0] rf_read1data,
  output logic [SELW-1:0]  rf_writeregsel,
  output logic [WIDTH-1:0] rf_writedata,
  output logic             rf_write,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready
);

  ctx_state_t      state;
  ctx_state_t      state_nxt;
  logic [SELW-1:0] idx;
  logic            idx_last;
  logic            idx_clr;
  logic            idx_inc;
  logic            capture;

  ctx_idx_counter #(
    .NREGS (NREGS),
    .SELW  (SELW)
  ) u_idx (
    .clk  (clk),
    .rst  (rst),
    .clr  (idx_clr),
    .inc  (idx_inc),
    .idx  (idx),
    .last (idx_last)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and per-state outputs; status outputs decode the state so
  // reset clears them immediately.
  always_comb begin
    state_nxt = state;
    idx_clr   = 1'b0;
    idx_inc   = 1'b0;
    capture   = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    out_valid = 1'b0;
    in_ready  = 1'b0;
    rf_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          idx_clr   = 1'b1;
          state_nxt = mode ? ST_RESTORE : ST_SAVE_RD;
        end
      end
      ST_SAVE_RD: begin
        busy      = 1'b1;
        capture   = 1'b1;
        state_nxt = ST_SAVE_OUT;
      end
      ST_SAVE_OUT: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (idx_last) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = ST_SAVE_RD;
          end
        end
      end
      ST_RESTORE: begin
        busy     = 1'b1;
        in_ready = 1'b1;
        rf_write = in_valid;
        if (in_valid) begin
          if (idx_last) begin
            state_nxt = ST_DONE;
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
      ST_DONE: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Save data register: loaded only from SAVE_RD so it stays stable while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data <= '0;
    end else if (capture) begin
      out_data <= rf_read1data;
    end
  end

  // A start outside idle is dropped and flagged for exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else begin
      err <= start && (state != ST_IDLE);
    end
  end

  assign rf_read1regsel = idx;
  assign rf_writeregsel = idx;
  assign rf_writedata   = in_data;

endmodule

// File: tb/tb_rf_ctx_seq.sv
// Directed bench for rf_ctx_seq with a behavioural register file.
module tb_rf_ctx_seq;
  import rf_pkg::*;

  localparam int WIDTH = WIDTH_DEF;
  localparam int NREGS = NREGS_DEF;
  localparam int SELW  = SELW_DEF;

  logic             clk = 1'b0;
  logic             rst;
  logic             start, mode;
  logic             busy, done, err;
  logic [SELW-1:0]  rf_read1regsel, rf_writeregsel;
  logic [WIDTH-1:0] rf_read1data, rf_writedata;
  logic             rf_write;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_valid, in_ready;

  logic [WIDTH-1:0] regs [NREGS];
  logic             pre_en;
  logic [WIDTH-1:0] pre_base;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  rf_ctx_seq dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mode           (mode),
    .busy           (busy),
    .done           (done),
    .err            (err),
    .rf_read1regsel (rf_read1regsel),
    .rf_read1data   (rf_read1data),
    .rf_writeregsel (rf_writeregsel),
    .rf_writedata   (rf_writedata),
    .rf_write       (rf_write),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready)
  );

  // Register file model: bulk preload from the bench, otherwise DUT writes.
  always @(posedge clk) begin
    if (pre_en) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= pre_base + WIDTH'(i);
    end else if (rf_write) begin
      regs[rf_writeregsel] <= rf_writedata;
    end
  end

  assign rf_read1data = regs[rf_read1regsel];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [WIDTH-1:0] base);
    @(negedge clk);
    pre_base = base;
    pre_en   = 1'b1;
    @(negedge clk);
    pre_en   = 1'b0;
  endtask

  // Collect a full save stream; stalls stall_n cycles on word stall_w.
  task automatic collect_save(input int stall_w, input int stall_n, input logic [WIDTH-1:0] base);
    int n = 0;
    int stalled = 0;
    bit got_done = 0;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      mode  = cyc[0];
      if (done) begin
        got_done = 1;
        out_ready = 1'b1;
      end else if (out_valid && n == stall_w && stalled < stall_n) begin
        check_val("stall_valid", {31'd0, out_valid}, 32'd1);
        check_val("stall_data", {16'd0, out_data}, {16'd0, base + WIDTH'(stall_w)});
        stalled++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          check_val("save_word", {16'd0, out_data}, {16'd0, base + WIDTH'(n)});
          n++;
        end
      end
    end
    check_val("save_count", n, NREGS);
    check_val("save_done_seen", {31'd0, got_done}, 32'd1);
  endtask

  // Run a restore of base+i with in_valid toggling per gap pattern.
  task automatic run_restore(input logic [WIDTH-1:0] base, input int abort_after);
    int n = 0;
    bit got_done = 0;
    @(negedge clk);
    start = 1'b1;
    mode  = 1'b1;
    for (int cyc = 0; cyc < 200 && !got_done; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        got_done = 1;
        in_valid = 1'b0;
      end else if (n == abort_after) begin
        rst = 1'b0;
        #1;
        check_val("rst_rf_write", {31'd0, rf_write}, 32'd0);
        check_val("rst_busy", {31'd0, busy}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        return;
      end else begin
        in_valid = (cyc % 3) != 1;
        in_data  = base + WIDTH'(n);
        #1;
        check_val("rs_in_ready", {31'd0, in_ready}, 32'd1);
        check_val("rs_rf_write", {31'd0, rf_write}, {31'd0, in_valid});
        if (in_valid) begin
          check_val("rs_sel", {29'd0, rf_writeregsel}, n);
          n++;
        end
      end
    end
    check_val("rs_done_seen", {31'd0, got_done}, 32'd1);
    @(negedge clk);
    for (int i = 0; i < NREGS; i++)
      check_val($sformatf("rs_reg%0d", i), {16'd0, regs[i]}, {16'd0, base + WIDTH'(i)});
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; mode = 1'b0; out_ready = 1'b1;
    in_data = '0; in_valid = 1'b0; pre_en = 1'b0; pre_base = '0;
    #12;
    check_val("rst_busy0", {31'd0, busy}, 32'd0);
    check_val("rst_done0", {31'd0, done}, 32'd0);
    check_val("rst_err0", {31'd0, err}, 32'd0);
    check_val("rst_oval0", {31'd0, out_valid}, 32'd0);
    check_val("rst_odata0", {16'd0, out_data}, 32'd0);
    check_val("rst_wr0", {31'd0, rf_write}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    preload(16'h1000);

    // Save with out_ready held high: cycle-exact timing.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_ready = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      start = 1'b0;
      check_val($sformatf("sv_valid_c%0d", c), {31'd0, out_valid},
                (c >= 2 && c <= 16 && c % 2 == 0) ? 32'd1 : 32'd0);
      check_val($sformatf("sv_done_c%0d", c), {31'd0, done}, (c == 17) ? 32'd1 : 32'd0);
      check_val($sformatf("sv_busy_c%0d", c), {31'd0, busy}, (c <= 16) ? 32'd1 : 32'd0);
      if (c >= 2 && c <= 16 && c % 2 == 0)
        check_val($sformatf("sv_data_c%0d", c), {16'd0, out_data}, 32'h1000 + (c - 2) / 2);
      if (c <= 15 && c % 2 == 1)
        check_val($sformatf("sv_sel_c%0d", c), {29'd0, rf_read1regsel}, (c - 1) / 2);
    end

    // Save with a five-cycle stall on word 3; mode wiggles during the run.
    @(negedge clk);
    start = 1'b1; mode = 1'b0;
    collect_save(3, 5, 16'h1000);

    // Illegal start during SAVE_OUT.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    check_val("il_in_saveout", {31'd0, out_valid}, 32'd1);
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("il_err_hi", {31'd0, err}, 32'd1);
    check_val("il_still_save", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    check_val("il_err_lo", {31'd0, err}, 32'd0);
    collect_save(0, 0, 16'h1000);

    // Restore with gaps.
    preload(16'h0000);
    run_restore(16'hA000, -1);
    check_val("post_rs_busy", {31'd0, busy}, 32'd0);
    check_val("post_rs_wr", {31'd0, rf_write}, 32'd0);

    // Reset mid-restore after 3 words, then a complete restore from index 0.
    run_restore(16'hC000, 3);
    check_val("abort_idle_busy", {31'd0, busy}, 32'd0);
    run_restore(16'hB000, -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/rf_ctx_seq.md
RF_CTX_SEQ -- requirements
Module: rf_ctx_seq

Interface
REQ-001 The parameter WIDTH SHALL default to 16 and set the register data width.
REQ-002 The parameter NREGS SHALL default to 8 and set the register count; SELW = log2(NREGS) = 3.
REQ-003 The ports SHALL be (name  direction  width  meaning):
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  request a context operation, sampled in IDLE only.
- mode  in  1  0 = save (register file to out stream), 1 = restore (in stream to register file); sampled with start.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse on an illegal start.
- rf_read1regsel  out  SELW  register file read select.
- rf_read1data  in  WIDTH  register file combinational read data.
- rf_writeregsel  out  SELW  register file write select.
- rf_writedata  out  WIDTH  register file write data.
- rf_write  out  1  register file write enable.
- out_data  out  WIDTH  save stream data, registered.
- out_valid  out  1  save stream valid.
- out_ready  in  1  save stream ready.
- in_data  in  WIDTH  restore stream data.
- in_valid  in  1  restore stream valid.
- in_ready  out  1  restore stream ready.

Function
REQ-004 The FSM SHALL have states IDLE, SAVE_RD, SAVE_OUT, RESTORE and DONE, with a SELW-bit index idx.
REQ-005 In IDLE with start=1, the FSM SHALL clear idx to 0 and go to SAVE_RD when mode=0, or to RESTORE when mode=1.
REQ-006 In SAVE_RD, rf_read1regsel SHALL equal idx; at the next edge out_data SHALL capture rf_read1data, out_valid SHALL go to 1, and the state SHALL go to SAVE_OUT.
REQ-007 In SAVE_OUT, out_valid and out_data SHALL hold stable until out_ready=1. On that handshake: if idx = NREGS-1, go to DONE; otherwise idx+1 and go to SAVE_RD. out_valid SHALL be 0 in every other state.
REQ-008 Save latency SHALL be: start at cycle 0, out_valid for register 0 at cycle 2; with out_ready held at 1, words SHALL come every 2 cycles.
REQ-009 In RESTORE, the block SHALL drive in_ready=1 and rf_writeregsel=idx, connect rf_writedata combinationally to in_data, and set rf_write = in_valid.
REQ-010 In RESTORE, each handshake (in_valid & in_ready) SHALL increment idx; at idx = NREGS-1 it SHALL go to DONE instead.
REQ-011 rf_write and in_ready SHALL be 0 in every state other than RESTORE.
REQ-012 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-013 busy SHALL be 1 in SAVE_RD, SAVE_OUT and RESTORE, and 0 in IDLE and DONE.
REQ-014 start=1 in any state other than IDLE SHALL be ignored and SHALL assert err for the next single cycle; the operation in progress SHALL be unaffected.
REQ-015 idx SHALL never wrap; the transition to DONE takes priority over incrementing idx.
REQ-016 While outside IDLE, changes on mode SHALL have no effect.

Reset
REQ-017 While rst=0, the state SHALL be IDLE and idx=0, and busy, done, err, out_valid, in_ready and rf_write SHALL all be 0, with out_data=0. All of these are asynchronous, including when reset occurs mid-operation.
REQ-018 A partially completed save or restore interrupted by reset SHALL be abandoned; there SHALL be no resume.

Structure
REQ-019 The FSM state encoding and the WIDTH, NREGS and SELW defaults SHALL live in the shared package rf_pkg.
REQ-020 The block SHALL contain one sub-module, ctx_idx_counter: a SELW-bit counter with clear, increment and a last flag (idx = NREGS-1).

Verification
REQ-021 Save with out_ready=1: preload the register file with r_i = 16'h1000+i, pulse start with mode=0. The out stream SHALL produce 1000..1007 in order, the first at cycle 2, then done at cycle 17.
REQ-022 Save with backpressure: hold out_ready=0 for 5 cycles on word 3. out_data SHALL stay 16'h1003 with out_valid=1 throughout, and no words SHALL be lost or duplicated.
REQ-023 Restore with gaps: send 16'hA000+i with in_valid toggling. Each register i SHALL read back A000+i, and rf_write SHALL pulse only on a handshake.
REQ-024 Illegal start: pulse start during SAVE_OUT. err SHALL go high for one cycle, and the save SHALL finish normally.
REQ-025 Reset mid-restore: drive rst=0 after 3 words. rf_write and busy SHALL drop immediately, and a later restore SHALL start at idx 0.
